fifo_rd_sched: RTL and testbench

- Read-side scheduler for the async FIFO. Shares the single FIFO read port between NUM_REQ consumers in the rclk domain.
- Drives rinc from the FIFO's registered empty flag and head data.
- Registers each popped word into one output stage, tagged with its owner.
- Arbitration is round-robin, with a per-owner burst limit of MAX_BURST.

---
 rtl/fifo_rd_sched.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: read-side scheduler for the async FIFO.
// Shares the single FIFO read port between NUM_REQ consumers in the rclk
// domain. Each popped word is registered into one output stage and tagged
// with its owner. Arbitration is round-robin, with a per-owner burst limit
// of MAX_BURST consecutive pops.
//
// Ports:
//   rclk, rst_n      read clock, async active-low reset
//   empty, rdata     FIFO registered empty flag and head word
//   rinc             combinational pop strobe to the FIFO
//   req, ack         per-consumer level request and accept of presented word
//   dout_valid       one-hot: held word is presented to this consumer
//   dout, owner      registered word and index of current/last owner
//
// Optional: define FIFO_RD_SCHED_STATS_EN to add word_cnt (drained words)
// and grant_switch_cnt (owner changes). Both are 16-bit saturating counters.
module fifo_rd_sched #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int OWW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OWW-1:0]        owner
`ifdef FIFO_RD_SCHED_STATS_EN
  ,
  output logic [15:0]           word_cnt,
  output logic [15:0]           grant_switch_cnt
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_param
    $error("fifo_rd_sched: NUM_REQ must be 2..8 and MAX_BURST >= 1");
  end

  localparam int             BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [OWW:0]   NREQ_W     = (OWW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0]    vld_q,   vld_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic [OWW-1:0]        owner_q, owner_d;
  logic [BCW-1:0]        burst_q, burst_d;
  // Cleared by reset so the very first pop always scans from owner+1 (i.e. 0)
  // and is not counted as an owner switch.
  logic                  granted_q, granted_d;

  logic                   drain, slot_free, keep, same;
  logic [2*NUM_REQ-1:0]   rot;
  logic [OWW-1:0]         k, scan_sel, sel;
  logic [OWW:0]           scan_sum;

  always_comb begin
    drain     = |(vld_q & ack);
    slot_free = ~(|vld_q) | drain;
    rinc      = ~empty & slot_free & (|req);

    // Rotate req so bit 0 is owner+1 and bit NUM_REQ-1 is owner itself;
    // the lowest set bit is then the round-robin winner.
    rot = {req, req} >> ({1'b0, owner_q} + 1'b1);
    k   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot[i]) k = OWW'(i);
    end
    scan_sum = {1'b0, owner_q} + {1'b0, k} + 1'b1;
    scan_sel = (scan_sum >= NREQ_W) ? OWW'(scan_sum - NREQ_W) : scan_sum[OWW-1:0];

    // rot[NUM_REQ-1] is req[owner_q]
    keep = granted_q & rot[NUM_REQ-1] & (burst_q < BURST_LAST);
    sel  = keep ? owner_q : scan_sel;
    same = granted_q & (sel == owner_q);

    vld_d     = vld_q;
    dout_d    = dout_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    granted_d = granted_q;
    if (rinc) begin
      // A pop replaces the held word even when it drains on this same edge.
      vld_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
      dout_d    = rdata;
      owner_d   = sel;
      granted_d = 1'b1;
      if (same) burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
      else      burst_d = '0;
    end else if (drain) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      dout_q    <= '0;
      owner_q   <= OWW'(NUM_REQ - 1);
      burst_q   <= '0;
      granted_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      dout_q    <= dout_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      granted_q <= granted_d;
    end
  end

  assign dout_valid = vld_q;
  assign dout       = dout_q;
  assign owner      = owner_q;

`ifdef FIFO_RD_SCHED_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] sw_cnt_q,   sw_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    if (drain && word_cnt_q != 16'hFFFF)                  word_cnt_d = word_cnt_q + 16'd1;
    if (rinc && granted_q && !same && sw_cnt_q != 16'hFFFF) sw_cnt_d = sw_cnt_q + 16'd1;
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      sw_cnt_q   <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
    end
  end

  assign word_cnt         = word_cnt_q;
  assign grant_switch_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Testbench for fifo_rd_sched (NUM_REQ=2, DATA_WIDTH=8, MAX_BURST=4).
// The bench models the FIFO as a queue; expected drained words are queued by
// the stimulus and compared by an independent monitor at each drain.
module tb_fifo_rd_sched;

  logic       rclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic [1:0] req   = 2'b00;
  logic [1:0] ack   = 2'b00;
  logic [1:0] dout_valid;
  logic [7:0] dout;
  logic [0:0] owner;
`ifdef FIFO_RD_SCHED_STATS_EN
  logic [15:0] word_cnt, grant_switch_cnt;
`endif

  fifo_rd_sched #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .empty      (empty),
    .rdata      (rdata),
    .rinc       (rinc),
    .req        (req),
    .ack        (ack),
    .dout_valid (dout_valid),
    .dout       (dout),
    .owner      (owner)
`ifdef FIFO_RD_SCHED_STATS_EN
    ,
    .word_cnt         (word_cnt),
    .grant_switch_cnt (grant_switch_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int         own;
    logic [7:0] data;
  } exp_t;

  logic [7:0] fq[$];
  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, want);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] d);
    fq.push_back(d);
  endtask

  task automatic exp_push(input int o, input logic [7:0] d);
    exp_t e;
    e.own  = o;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    req = 2'b00;
    ack = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // FIFO model: the pop decision is taken at the edge, the queue and flags
  // are updated shortly after so the DUT samples the old head word.
  initial begin
    logic do_pop;
    forever begin
      @(posedge rclk);
      do_pop = rst_n && rinc;
      #2;
      if (do_pop && fq.size() > 0) void'(fq.pop_front());
      empty = (fq.size() == 0);
      rdata = (fq.size() == 0) ? 8'h00 : fq[0];
    end
  end

  // Monitor: every drain must match the next expected (owner, word).
  always @(negedge rclk) begin
    exp_t e;
    if (rst_n && |(dout_valid & ack)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL mon_unexpected: drained dout=%0h owner=%0d, expected no drain", dout, owner);
      end else begin
        e = exp_q.pop_front();
        chk("mon_owner",  {31'd0, owner}, e.own);
        chk("mon_data",   {24'd0, dout}, {24'd0, e.data});
        chk("mon_onehot", {30'd0, dout_valid}, 32'd1 << e.own);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         own_exp [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  logic [11:0] rpat;

  initial begin
    // ---- reset state and first grant ----
    do_reset();
    @(negedge rclk);
    chk("rst_vld",   {30'd0, dout_valid}, 0);
    chk("rst_owner", {31'd0, owner}, 1);
    chk("rst_dout",  {24'd0, dout}, 0);
    chk("rst_rinc",  {31'd0, rinc}, 0);
    tick();
    fifo_push(8'hA0);
    exp_push(0, 8'hA0);
    req = 2'b11;
    @(negedge rclk);
    chk("first_rinc", {31'd0, rinc}, 1);
    tick();
    @(negedge rclk);
    chk("first_vld",  {30'd0, dout_valid}, 32'h1);
    chk("first_dout", {24'd0, dout}, 32'hA0);
    chk("first_rinc_empty", {31'd0, rinc}, 0);
    tick();
    ack = 2'b01;
    tick();
    ack = 2'b00;
    req = 2'b00;
    @(negedge rclk);
    chk("first_drained", {30'd0, dout_valid}, 0);
    chk("first_exp_left", exp_q.size(), 0);

    // ---- streaming with burst limit ----
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) begin
      fifo_push(8'(i));
      exp_push(own_exp[i], 8'(i));
    end
    req = 2'b11;
    ack = 2'b11;
    rpat = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      rpat[c] = rinc;
      tick();
    end
    chk("stream_rinc_pattern", {20'd0, rpat}, 32'h3FF);
    @(negedge rclk);
    chk("stream_exp_left", exp_q.size(), 0);
    chk("stream_empty_vld", {30'd0, dout_valid}, 0);
`ifdef FIFO_RD_SCHED_STATS_EN
    chk("stats_word_cnt", {16'd0, word_cnt}, 10);
    chk("stats_switch_cnt", {16'd0, grant_switch_cnt}, 2);
`endif

    // ---- backpressure ----
    do_reset();
    tick();
    fifo_push(8'h55);
    fifo_push(8'h66);
    exp_push(1, 8'h55);
    exp_push(1, 8'h66);
    req = 2'b10;
    @(negedge rclk);
    chk("bp_rinc_first", {31'd0, rinc}, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      chk("bp_hold_vld",  {30'd0, dout_valid}, 32'h2);
      chk("bp_hold_dout", {24'd0, dout}, 32'h55);
      chk("bp_hold_rinc", {31'd0, rinc}, 0);
      tick();
    end
    ack = 2'b10;
    @(negedge rclk);
    chk("bp_release_rinc", {31'd0, rinc}, 1);
    tick();
    @(negedge rclk);
    chk("bp_next_vld",  {30'd0, dout_valid}, 32'h2);
    chk("bp_next_dout", {24'd0, dout}, 32'h66);
    tick();
    ack = 2'b00;
    req = 2'b00;
    @(negedge rclk);
    chk("bp_done_vld", {30'd0, dout_valid}, 0);
    chk("bp_exp_left", exp_q.size(), 0);

    // ---- commitment and foreign ack ----
    do_reset();
    tick();
    fifo_push(8'h77);
    exp_push(0, 8'h77);
    req = 2'b01;
    @(negedge rclk);
    chk("cm_rinc", {31'd0, rinc}, 1);
    tick();
    req = 2'b00;
    ack = 2'b10;
    @(negedge rclk);
    chk("cm_foreign_vld",  {30'd0, dout_valid}, 32'h1);
    chk("cm_foreign_dout", {24'd0, dout}, 32'h77);
    tick();
    ack = 2'b00;
    @(negedge rclk);
    chk("cm_still_held", {30'd0, dout_valid}, 32'h1);
    tick();
    ack = 2'b01;
    tick();
    ack = 2'b00;
    @(negedge rclk);
    chk("cm_drained", {30'd0, dout_valid}, 0);
    chk("cm_exp_left", exp_q.size(), 0);

    // ---- empty boundary and async reset while held ----
    do_reset();
    tick();
    req = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      chk("em_no_rinc", {31'd0, rinc}, 0);
      tick();
    end
    fifo_push(8'h88);
    req = 2'b01;
    @(negedge rclk);
    chk("em_rinc", {31'd0, rinc}, 1);
    tick();
    chk("ar_held", {30'd0, dout_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_vld",   {30'd0, dout_valid}, 0);
    chk("ar_owner", {31'd0, owner}, 1);
    chk("ar_dout",  {24'd0, dout}, 0);
    do_reset();
    @(negedge rclk);
    chk("ar_post_vld", {30'd0, dout_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
